// File: rtl/fifo_read_packer.sv
// Read-side packer for the CDC FIFO: pops entries and packs PACK_COUNT of them, little-endian,
// into one wide word on a valid/ready output. A flush emits a partially filled word with its count.
module fifo_read_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_COUNT = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                fifo_read_data,
  input  logic                                 fifo_empty,
  output logic                                 fifo_read_increment,
  input  logic                                 flush,
  output logic [DATA_WIDTH*PACK_COUNT-1:0]     out_data,
  output logic [$clog2(PACK_COUNT+1)-1:0]      out_count,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int unsigned IdxW  = $clog2(PACK_COUNT);
  localparam int unsigned CntW  = $clog2(PACK_COUNT + 1);
  localparam int unsigned WordW = DATA_WIDTH * PACK_COUNT;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PACK_COUNT - 1);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   fill_idx_q, fill_idx_d;
  logic [WordW-1:0]  data_q, data_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              valid_q, valid_d;

  // Pop is purely combinational so the FIFO head is consumed on the same edge it is captured.
  assign fifo_read_increment = !reset && (state_q == StFill) && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    data_d     = data_q;
    count_d    = count_q;
    valid_d    = valid_q;
    unique case (state_q)
      StFill: begin
        if (fifo_read_increment) begin
          for (int k = 0; k < PACK_COUNT; k++) begin
            if (fill_idx_q == IdxW'(k)) data_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_read_data;
          end
          if (fill_idx_q == LastIdx) begin
            count_d    = CntW'(PACK_COUNT);
            fill_idx_d = '0;
            valid_d    = 1'b1;
            state_d    = StHold;
          end else if (flush) begin
            count_d    = CntW'(fill_idx_q) + CntW'(1);
            fill_idx_d = '0;
            valid_d    = 1'b1;
            state_d    = StHold;
          end else begin
            fill_idx_d = fill_idx_q + IdxW'(1);
          end
        end else if (flush && (fill_idx_q != '0)) begin
          // Flush with nothing collected is dropped: a zero-count word is never emitted.
          count_d    = CntW'(fill_idx_q);
          fill_idx_d = '0;
          valid_d    = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          // Clearing here keeps unwritten lanes of the next word at zero.
          data_d  = '0;
          count_d = '0;
          valid_d = 1'b0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StFill;
      fill_idx_q <= '0;
      data_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      data_q     <= data_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Randomised scoreboard bench for fifo_read_packer: two instances (PACK_COUNT 4 and 3) fed from
// queue-modelled FIFOs; expected words are built from the popped entry stream and flush events.
module tb_fifo_read_packer;

  localparam int NI = 2;

  typedef struct {
    logic [31:0] data;
    int          cnt;
  } word_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  rdd0, rdd1;
  logic        empty0, empty1;
  logic        pop0, pop1;
  logic [31:0] od0;
  logic [23:0] od1;
  logic [2:0]  oc0;
  logic [1:0]  oc1;
  logic        ov0, ov1;

  logic [7:0] fq  [NI][$];
  logic [7:0] acc [NI][$];
  word_t      sb  [NI][$];
  bit         hold [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fifo_read_packer #(.DATA_WIDTH(8), .PACK_COUNT(4)) u_pc4 (
    .clock               (clock),
    .reset               (reset),
    .fifo_read_data      (rdd0),
    .fifo_empty          (empty0),
    .fifo_read_increment (pop0),
    .flush               (flush),
    .out_data            (od0),
    .out_count           (oc0),
    .out_valid           (ov0),
    .out_ready           (out_ready)
  );

  fifo_read_packer #(.DATA_WIDTH(8), .PACK_COUNT(3)) u_pc3 (
    .clock               (clock),
    .reset               (reset),
    .fifo_read_data      (rdd1),
    .fifo_empty          (empty1),
    .fifo_read_increment (pop1),
    .flush               (flush),
    .out_data            (od1),
    .out_count           (oc1),
    .out_valid           (ov1),
    .out_ready           (out_ready)
  );

  function automatic int pc_of(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic logic [31:0] word_of(int i);
    return (i == 0) ? od0 : {8'h00, od1};
  endfunction

  function automatic logic [31:0] count_of(int i);
    return (i == 0) ? 32'(oc0) : 32'(oc1);
  endfunction

  function automatic logic valid_of(int i);
    return (i == 0) ? ov0 : ov1;
  endfunction

  function automatic logic pop_of(int i);
    return (i == 0) ? pop0 : pop1;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0h, required %0h", name, i, $time, act, exp);
    end
  endtask

  task automatic drive(input bit fl, input bit rdy, input bit add);
    flush     = fl;
    out_ready = rdy;
    for (int i = 0; i < NI; i++) begin
      if (add && fq[i].size() < 6 && $urandom_range(0, 2) != 0) fq[i].push_back(8'($urandom));
    end
    empty0 = (fq[0].size() == 0);
    empty1 = (fq[1].size() == 0);
    rdd0   = empty0 ? 8'($urandom) : fq[0][0];
    rdd1   = empty1 ? 8'($urandom) : fq[1][0];
  endtask

  task automatic emit(input int i);
    word_t w;
    w.data = '0;
    for (int k = 0; k < acc[i].size(); k++) w.data |= 32'(acc[i][k]) << (8 * k);
    w.cnt = acc[i].size();
    sb[i].push_back(w);
    acc[i].delete();
    hold[i] = 1'b1;
  endtask

  // Behavioural step for the coming clock edge: either holding a word, or collecting entries.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      bit ep;
      ep = !hold[i] && (fq[i].size() != 0);
      check("pop_strobe", i, 32'(pop_of(i)), 32'(ep));
      check("out_valid", i, 32'(valid_of(i)), 32'(hold[i]));
      if (hold[i]) begin
        if (out_ready) hold[i] = 1'b0;
      end else if (ep) begin
        acc[i].push_back(fq[i].pop_front());
        if (acc[i].size() == pc_of(i) || flush) emit(i);
      end else if (flush && acc[i].size() != 0) begin
        emit(i);
      end
    end
  endtask

  task automatic cycle(input bit fl, input bit rdy, input bit add);
    @(posedge clock);
    #1;
    drive(fl, rdy, add);
    #3;
    model_step();
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      acc[i].delete();
      sb[i].delete();
      hold[i] = 1'b0;
    end
    drive(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < cycles; c++) begin
      #3;
      for (int i = 0; i < NI; i++) begin
        check("reset_pop", i, 32'(pop_of(i)), 32'd0);
        check("reset_valid", i, 32'(valid_of(i)), 32'd0);
        check("reset_data", i, word_of(i), 32'd0);
        check("reset_count", i, count_of(i), 32'd0);
      end
      @(posedge clock);
      #1;
      drive(1'b0, 1'b1, 1'b1);
    end
    reset = 1'b0;
    #3;
    model_step();
  endtask

  // Monitor: whenever a word is presented it must match the scoreboard head; pop on handshake.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        if (valid_of(i)) begin
          if (sb[i].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word inst%0d @%0t: got data %0h count %0d, required none",
                     i, $time, word_of(i), count_of(i));
          end else begin
            check("word_data", i, word_of(i), sb[i][0].data);
            check("word_count", i, count_of(i), 32'(sb[i][0].cnt));
            if (out_ready) sb[i].delete(0);
          end
        end
      end
    end
  end

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++) begin
      if (fq[i].size() != 0 || acc[i].size() != 0 || hold[i] || sb[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    empty0 = 1'b1;
    empty1 = 1'b1;
    rdd0   = '0;
    rdd1   = '0;
    for (int i = 0; i < NI; i++) hold[i] = 1'b0;
    apply_reset(3);
    for (int i = 0; i < NI; i++) fq[i].delete();

    // Straight stream: 11,22,33,44 into PC=4 and 1..9 into PC=3.
    fq[0].push_back(8'h11); fq[0].push_back(8'h22);
    fq[0].push_back(8'h33); fq[0].push_back(8'h44);
    for (int v = 1; v <= 9; v++) fq[1].push_back(8'(v));
    repeat (16) cycle(1'b0, 1'b1, 1'b0);

    // Backpressure with entries waiting, then release.
    for (int i = 0; i < NI; i++) repeat (5) fq[i].push_back(8'($urandom));
    repeat (14) cycle(1'b0, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0);

    // Flush with FIFO empty after two pops, then flush with nothing collected.
    for (int i = 0; i < NI; i++) begin
      fq[i].push_back(8'hAA);
      fq[i].push_back(8'hBB);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);

    // Flush coincident with the third pop; a further flush lands during HOLD.
    for (int i = 0; i < NI; i++) begin
      fq[i].push_back(8'hAA);
      fq[i].push_back(8'hBB);
    end
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NI; i++) fq[i].push_back(8'hCC);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    // Reset after two pops of a word discards the partial word.
    for (int i = 0; i < NI; i++) for (int v = 1; v <= 5; v++) fq[i].push_back(8'(v));
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    apply_reset(2);
    repeat (12) cycle(1'b0, 1'b1, 1'b0);

    // Random traffic with occasional resets.
    repeat (3000) begin
      if ($urandom_range(0, 599) == 0) apply_reset(2);
      else cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, 1'b1);
    end

    // Drain everything that is left, bounded.
    for (int c = 0; c < 300 && !all_idle(); c++) cycle((c % 4) == 0, 1'b1, 1'b0);
    repeat (2) @(posedge clock);
    n_checks++;
    if (!all_idle()) begin
      n_fail++;
      $display("FAIL drain: got pending words/entries, required all drained");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
